// File: rtl/comparador_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result triple
// and the 7485 cascade-input truth table.
package comparador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    typedef struct packed {
        logic maior;
        logic menor;
        logic igual;
    } resultado_t;

    localparam int unsigned RES_W = 3;

    // Outcome when every digit matched: the lower-order block decides.
    function automatic resultado_t cascata_resultado(input resultado_t c);
        resultado_t r;
        r = '0;
        if (c.igual) begin
            r.igual = 1'b1;
        end else begin
            case ({c.maior, c.menor})
                2'b10:   r.maior = 1'b1;
                2'b01:   r.menor = 1'b1;
                2'b11:   r = '0;
                default: begin
                    r.maior = 1'b1;
                    r.menor = 1'b1;
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/comparador_serial_param_if.sv
// Start/operand/cascade inputs and registered result outputs of the comparator.
interface comparador_serial_param_if #(
    parameter int unsigned DIG_W = 4,
    parameter int unsigned N_DIG = 4
);
    localparam int unsigned WIDTH = DIG_W * N_DIG;
    localparam int unsigned CNT_W = $clog2(N_DIG + 1);

    logic             iniciar;
    logic             modo_sinal;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cascata_maior;
    logic             cascata_menor;
    logic             cascata_igual;
    logic             ocupado;
    logic             pronto;
    logic             A_maior_que_B;
    logic             A_menor_que_B;
    logic             A_igual_a_B;
    logic [CNT_W-1:0] digitos_usados;

    modport master (
        output iniciar, modo_sinal, A, B, cascata_maior, cascata_menor, cascata_igual,
        input  ocupado, pronto, A_maior_que_B, A_menor_que_B, A_igual_a_B, digitos_usados
    );

    modport slave (
        input  iniciar, modo_sinal, A, B, cascata_maior, cascata_menor, cascata_igual,
        output ocupado, pronto, A_maior_que_B, A_menor_que_B, A_igual_a_B, digitos_usados
    );
endinterface

// File: rtl/comparador_digito.sv
// Combinational single-digit magnitude compare.
module comparador_digito #(
    parameter int unsigned DIG_W = 4
) (
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/comparador_serial_param.sv
// Digit-serial MSB-first magnitude comparator with signed mode, optional early
// exit, 7485-style cascade inputs and a start/done handshake.
module comparador_serial_param
    import comparador_pkg::*;
#(
    parameter int unsigned DIG_W      = 4,
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    comparador_serial_param_if.slave    bus
);
    localparam int unsigned WIDTH = DIG_W * N_DIG;
    localparam int unsigned CNT_W = $clog2(N_DIG + 1);
    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    resultado_t       cas_q, cas_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dif_valida_q, dif_valida_d;
    resultado_t       dif_q, dif_d;
    resultado_t       res_q, res_d;
    logic [CNT_W-1:0] usados_q, usados_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;

    logic [DIG_W-1:0] dig_a, dig_b;
    logic             dig_gt, dig_lt, dig_eq;

    assign dig_a = a_q[32'(idx_q) * DIG_W +: DIG_W];
    assign dig_b = b_q[32'(idx_q) * DIG_W +: DIG_W];

    comparador_digito #(.DIG_W(DIG_W)) u_digito (
        .a  (dig_a),
        .b  (dig_b),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= OCIOSO;
            a_q          <= '0;
            b_q          <= '0;
            cas_q        <= '0;
            idx_q        <= '0;
            dif_valida_q <= 1'b0;
            dif_q        <= '0;
            res_q        <= '0;
            usados_q     <= '0;
            pronto_q     <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cas_q        <= cas_d;
            idx_q        <= idx_d;
            dif_valida_q <= dif_valida_d;
            dif_q        <= dif_d;
            res_q        <= res_d;
            usados_q     <= usados_d;
            pronto_q     <= pronto_d;
            ocupado_q    <= ocupado_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        a_d          = a_q;
        b_d          = b_q;
        cas_d        = cas_q;
        idx_d        = idx_q;
        dif_valida_d = dif_valida_q;
        dif_d        = dif_q;
        res_d        = res_q;
        usados_d     = usados_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    a_d = bus.A;
                    b_d = bus.B;
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    if (bus.modo_sinal) begin
                        a_d[WIDTH-1] = ~bus.A[WIDTH-1];
                        b_d[WIDTH-1] = ~bus.B[WIDTH-1];
                    end
                    cas_d.maior  = bus.cascata_maior;
                    cas_d.menor  = bus.cascata_menor;
                    cas_d.igual  = bus.cascata_igual;
                    idx_d        = IDX_W'(N_DIG - 1);
                    dif_valida_d = 1'b0;
                    dif_d        = '0;
                    estado_d     = COMPARA;
                end
            end
            COMPARA: begin
                if (!dig_eq && (EARLY_EXIT != 0)) begin
                    res_d    = '{maior: dig_gt, menor: dig_lt, igual: 1'b0};
                    usados_d = CNT_W'(N_DIG - 32'(idx_q));
                    estado_d = FIM;
                end else begin
                    // Fixed-latency mode keeps only the most significant difference.
                    if (!dig_eq && !dif_valida_q) begin
                        dif_valida_d = 1'b1;
                        dif_d        = '{maior: dig_gt, menor: dig_lt, igual: 1'b0};
                    end
                    if (idx_q == '0) begin
                        usados_d = CNT_W'(N_DIG);
                        estado_d = FIM;
                        if (dif_valida_q) begin
                            res_d = dif_q;
                        end else if (!dig_eq) begin
                            res_d = '{maior: dig_gt, menor: dig_lt, igual: 1'b0};
                        end else begin
                            res_d = cascata_resultado(cas_q);
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        ocupado_d = (estado_d != OCIOSO);
        pronto_d  = (estado_d == FIM);
    end

    assign bus.ocupado        = ocupado_q;
    assign bus.pronto         = pronto_q;
    assign bus.A_maior_que_B  = res_q.maior;
    assign bus.A_menor_que_B  = res_q.menor;
    assign bus.A_igual_a_B    = res_q.igual;
    assign bus.digitos_usados = usados_q;

endmodule

// File: tb/tb_comparador_serial_param.sv
// Randomised and directed checks of the serial comparator, early-exit and
// fixed-latency builds side by side, against an arithmetic reference model.
module tb_comparador_serial_param;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned N_DIG = 4;
    localparam int unsigned W     = DIG_W * N_DIG;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clock = ~clock;

    comparador_serial_param_if #(.DIG_W(DIG_W), .N_DIG(N_DIG)) bus1 ();
    comparador_serial_param_if #(.DIG_W(DIG_W), .N_DIG(N_DIG)) bus0 ();

    comparador_serial_param #(.DIG_W(DIG_W), .N_DIG(N_DIG), .EARLY_EXIT(1)) dut_ee1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    comparador_serial_param #(.DIG_W(DIG_W), .N_DIG(N_DIG), .EARLY_EXIT(0)) dut_ee0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic ini, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic modo, input logic [2:0] cas);
        bus1.iniciar = ini; bus1.A = a; bus1.B = b; bus1.modo_sinal = modo;
        bus1.cascata_maior = cas[2]; bus1.cascata_menor = cas[1]; bus1.cascata_igual = cas[0];
        bus0.iniciar = ini; bus0.A = a; bus0.B = b; bus0.modo_sinal = modo;
        bus0.cascata_maior = cas[2]; bus0.cascata_menor = cas[1]; bus0.cascata_igual = cas[0];
    endtask

    // Expected {maior, menor, igual} from the numeric order of the operands.
    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic modo, input logic [2:0] cas);
        if (a == b) begin
            if (cas[0]) return 3'b001;
            case (cas[2:1])
                2'b10:   return 3'b100;
                2'b01:   return 3'b010;
                2'b11:   return 3'b000;
                default: return 3'b110;
            endcase
        end
        if (modo) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b010;
        return (a > b) ? 3'b100 : 3'b010;
    endfunction

    // Early-exit digit count: fewest leading digits whose XOR is nonzero.
    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        for (int d = 1; d <= N_DIG; d++) begin
            if ((x >> (W - d * DIG_W)) != '0) return d;
        end
        return N_DIG;
    endfunction

    function automatic logic [2:0] res_of1();
        return {bus1.A_maior_que_B, bus1.A_menor_que_B, bus1.A_igual_a_B};
    endfunction

    function automatic logic [2:0] res_of0();
        return {bus0.A_maior_que_B, bus0.A_menor_que_B, bus0.A_igual_a_B};
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic modo, input logic [2:0] cas, input bit disturb);
        logic [2:0] exp;
        int k1, first1, first0, cnt1, cnt0;
        exp = ref_res(a, b, modo, cas);
        k1  = ref_k(a, b);
        first1 = 0; first0 = 0; cnt1 = 0; cnt0 = 0;
        set_in(1'b1, a, b, modo, cas);
        @(posedge clock); #1;
        set_in(1'b0, W'($urandom), W'($urandom), ~modo, ~cas);
        for (int n = 1; n <= int'(N_DIG) + 3; n++) begin
            @(posedge clock); #1;
            if (bus1.pronto) begin cnt1++; if (first1 == 0) first1 = n; end
            if (bus0.pronto) begin cnt0++; if (first0 == 0) first0 = n; end
            if (n == 1) begin
                check({tag, " ocup1"}, 32'(bus1.ocupado), 32'd1);
                check({tag, " ocup0"}, 32'(bus0.ocupado), 32'd1);
            end
            if (disturb && n == 1) set_in(1'b1, ~a, b ^ W'($urandom), ~modo, ~cas);
            if (disturb && n == 2) set_in(1'b0, a, b, modo, cas);
        end
        check({tag, " lat1"},  32'(first1), 32'(k1));
        check({tag, " lat0"},  32'(first0), 32'(N_DIG));
        check({tag, " npr1"},  32'(cnt1), 32'd1);
        check({tag, " npr0"},  32'(cnt0), 32'd1);
        check({tag, " res1"},  32'(res_of1()), 32'(exp));
        check({tag, " res0"},  32'(res_of0()), 32'(exp));
        check({tag, " dig1"},  32'(bus1.digitos_usados), 32'(k1));
        check({tag, " dig0"},  32'(bus0.digitos_usados), 32'(N_DIG));
        check({tag, " idle"},  32'({bus1.ocupado, bus0.ocupado}), 32'd0);
    endtask

    initial begin
        int p1, p0;
        logic [W-1:0] ra, rb;
        set_in(1'b0, '0, '0, 1'b0, 3'b000);
        repeat (3) @(posedge clock);
        #1;
        check("rst res1", 32'(res_of1()), 32'd0);
        check("rst hs1",  32'({bus1.ocupado, bus1.pronto, bus1.digitos_usados}), 32'd0);
        check("rst hs0",  32'({bus0.ocupado, bus0.pronto, bus0.digitos_usados}), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op("t1",   16'h1234, 16'h1235, 1'b0, 3'b001, 1'b0);
        run_op("t2",   16'h9000, 16'h1FFF, 1'b0, 3'b001, 1'b0);
        run_op("t3s",  16'h8000, 16'h0001, 1'b1, 3'b001, 1'b0);
        run_op("t3u",  16'h8000, 16'h0001, 1'b0, 3'b001, 1'b0);
        run_op("c000", 16'hFFFF, 16'hFFFF, 1'b0, 3'b000, 1'b0);
        run_op("c111", 16'hFFFF, 16'hFFFF, 1'b0, 3'b111, 1'b0);
        run_op("c100", 16'hFFFF, 16'hFFFF, 1'b0, 3'b100, 1'b0);
        run_op("c010", 16'hFFFF, 16'hFFFF, 1'b1, 3'b010, 1'b0);
        run_op("c110", 16'hFFFF, 16'hFFFF, 1'b0, 3'b110, 1'b0);

        // Abort two cycles into COMPARA.
        set_in(1'b1, 16'h1234, 16'h1235, 1'b0, 3'b001);
        @(posedge clock); #1;
        set_in(1'b0, 16'h1234, 16'h1235, 1'b0, 3'b001);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort res1", 32'(res_of1()), 32'd0);
        check("abort res0", 32'(res_of0()), 32'd0);
        check("abort hs",   32'({bus1.ocupado, bus1.pronto, bus0.ocupado, bus0.pronto}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        p1 = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            if (bus1.pronto || bus0.pronto || bus1.ocupado || bus0.ocupado) p1++;
        end
        check("abort quiet", 32'(p1), 32'd0);
        run_op("post", 16'h00A0, 16'h00A0, 1'b0, 3'b100, 1'b0);

        run_op("ign1", 16'h4321, 16'h4320, 1'b0, 3'b001, 1'b1);
        run_op("ign2", 16'h9000, 16'h1FFF, 1'b1, 3'b001, 1'b1);

        // Back-to-back with iniciar held high.
        set_in(1'b1, 16'h9000, 16'h1FFF, 1'b0, 3'b001);
        p1 = 0; p0 = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (bus1.pronto) p1++;
            if (bus0.pronto) p0++;
        end
        set_in(1'b0, 16'h0000, 16'hFFFF, 1'b0, 3'b010);
        repeat (8) @(posedge clock);
        #1;
        check("b2b npr1", 32'(p1), 32'd7);
        check("b2b npr0", 32'(p0), 32'd3);
        check("b2b res0", 32'(res_of0()), 32'b100);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
            if ($urandom_range(1) == 0) rb = (ra & 16'hFF00) | (rb & 16'h00FF);
            run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 3'($urandom), 1'($urandom_range(3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", total, 0);
        $fatal(1);
    end
endmodule
